// File: rtl/dw03_reg_pipe_hs_pkg.sv
// Shared helpers for the dw03 handshake pipeline register.
package dw03_pkg;

  // Ceiling log2: the number of bits needed to count 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dw03_reg_pipe_hs_if.sv
// Producer/consumer handshake bundle for dw03_reg_pipe_hs.
// The slave modport is the pipeline side; master is whoever drives it.
interface dw03_reg_pipe_hs_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  import dw03_pkg::*;

  localparam int CNT_W = clog2(DEPTH + 1);

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] count;

  modport master (
    output clear, in_valid, d, out_ready,
    input  in_ready, out_valid, q, count
  );

  modport slave (
    input  clear, in_valid, d, out_ready,
    output in_ready, out_valid, q, count
  );

endinterface

// File: rtl/dw03_reg_pipe_hs_stage.sv
// One pipeline slot: a valid flag plus a data word that only changes on load.
module dw03_pipe_stage #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CLR_DATA    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             clear,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] d,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  // Valid flag: clear wins, then a new word, then the word leaving.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)   v <= 1'b0;
    else if (clear) v <= 1'b0;
    else if (load)  v <= 1'b1;
    else if (adv)   v <= 1'b0;
  end

  // Data register: written only on a real load so idle slots never toggle.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)                 data <= RESET_VALUE;
    else if (clear && CLR_DATA)   data <= RESET_VALUE;
    else if (load && !clear)      data <= d;
  end

endmodule

// File: rtl/dw03_reg_pipe_hs.sv
// DEPTH-stage retiming register with valid/ready on both sides.
// Bubbles collapse under back-pressure; the ready path ripples
// combinationally from out_ready back to in_ready (no skid buffer).
module dw03_reg_pipe_hs
  import dw03_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CLR_DATA    = 1'b0
) (
  input  logic                clk,
  input  logic                reset_N,
  dw03_reg_pipe_hs_if.slave   bus
);

  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] stage_in [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic             in_ready_c;

  // Advance chain: a stage moves on when the next slot is free or itself moving.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v[DEPTH-1] & bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    end
  end

  // Input acceptance is blocked during reset and flush.
  assign in_ready_c = reset_N & ~bus.clear & (~v[0] | adv[0]);

  // Each stage loads from the input port or from the stage upstream of it.
  always_comb begin
    load = '0;
    load[0] = bus.in_valid & in_ready_c;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // Stage k boundary
    if (k == 0) begin : g_first
      assign stage_in[k] = bus.d;
    end else begin : g_next
      assign stage_in[k] = data[k-1];
    end

    dw03_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .CLR_DATA    (CLR_DATA)
    ) u_stage (
      .clk     (clk),
      .reset_N (reset_N),
      .clear   (bus.clear),
      .load    (load[k]),
      .adv     (adv[k]),
      .d       (stage_in[k]),
      .v       (v[k]),
      .data    (data[k])
    );
  end

  // Occupancy: +1 on accept, -1 on emit; flush empties it.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)       count_r <= '0;
    else if (bus.clear) count_r <= '0;
    else                count_r <= count_r + CNT_W'(load[0]) - CNT_W'(adv[DEPTH-1]);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.q         = data[DEPTH-1];
  assign bus.count     = count_r;

endmodule

// File: tb/tb_dw03_reg_pipe_hs.sv
// Directed bench for dw03_reg_pipe_hs: a DEPTH=3 byte pipe and a DEPTH=1 word pipe.
module tb_dw03_reg_pipe_hs;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dw03_reg_pipe_hs_if #(.WIDTH(8),  .DEPTH(3)) ifa ();
  dw03_reg_pipe_hs_if #(.WIDTH(32), .DEPTH(1)) ifb ();

  dw03_reg_pipe_hs #(
    .WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5), .CLR_DATA(1'b1)
  ) dut_a (
    .clk(clk), .reset_N(rst_a_n), .bus(ifa)
  );

  dw03_reg_pipe_hs #(
    .WIDTH(32), .DEPTH(1), .RESET_VALUE(32'hDEADBEEF), .CLR_DATA(1'b0)
  ) dut_b (
    .clk(clk), .reset_N(rst_b_n), .bus(ifb)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b1;
    #1 rst_a_n = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ifa.out_valid); else passes++;
    checks++; if (ifa.count !== 2'd0) $display("FAIL rst_count got %0d exp 0", ifa.count); else passes++;
    checks++; if (ifa.q !== 8'hA5) $display("FAIL rst_q got %h exp a5", ifa.q); else passes++;
    checks++; if (ifa.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", ifa.in_ready); else passes++;
    cyc();
    rst_a_n = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b exp 1", ifa.in_ready); else passes++;
    cyc();
    // two words held under stall, then reset mid-stream
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.d = 8'h11; cyc();
    ifa.d = 8'h22; cyc();
    ifa.in_valid = 1'b0; cyc();
    checks++; if (ifa.count !== 2'd2) $display("FAIL mid_count got %0d exp 2", ifa.count); else passes++;
    checks++; if (ifa.q !== 8'h11 || ifa.out_valid !== 1'b1) $display("FAIL mid_q got %h/%b exp 11/1", ifa.q, ifa.out_valid); else passes++;
    #1 rst_a_n = 1'b0;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) $display("FAIL async_out_valid got %b exp 0", ifa.out_valid); else passes++;
    checks++; if (ifa.count !== 2'd0) $display("FAIL async_count got %0d exp 0", ifa.count); else passes++;
    checks++; if (ifa.q !== 8'hA5) $display("FAIL async_q got %h exp a5", ifa.q); else passes++;
    checks++; if (ifa.in_ready !== 1'b0) $display("FAIL async_in_ready got %b exp 0", ifa.in_ready); else passes++;
    cyc();
    rst_a_n = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL async_release_in_ready got %b exp 1", ifa.in_ready); else passes++;
    cyc();
  endtask

  task automatic test_stream();
    bit ev;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      ifa.in_valid = (i < 16);
      ifa.d = (i < 16) ? 8'(i + 1) : 8'h00;
      #1;
      if (i < 16) begin
        checks++; if (ifa.in_ready !== 1'b1) $display("FAIL stream_in_ready i=%0d got %b exp 1", i, ifa.in_ready); else passes++;
      end
      cyc();
      ev = (i >= 2 && i <= 17);
      checks++; if (ifa.out_valid !== ev) $display("FAIL stream_out_valid i=%0d got %b exp %b", i, ifa.out_valid, ev); else passes++;
      if (ev) begin
        checks++; if (ifa.q !== 8'(i - 1)) $display("FAIL stream_q i=%0d got %h exp %h", i, ifa.q, 8'(i - 1)); else passes++;
      end
      if (i >= 2 && i <= 15) begin
        checks++; if (ifa.count !== 2'd3) $display("FAIL stream_count i=%0d got %0d exp 3", i, ifa.count); else passes++;
      end
    end
    checks++; if (ifa.count !== 2'd0) $display("FAIL stream_drained_count got %0d exp 0", ifa.count); else passes++;
  endtask

  task automatic test_backpressure();
    int s;
    s = 0;
    ifa.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      ifa.in_valid = 1'b1;
      ifa.d = 8'(8'h21 + s);
      #1;
      checks++; if (ifa.in_ready !== (j < 3)) $display("FAIL bp_in_ready j=%0d got %b exp %b", j, ifa.in_ready, (j < 3)); else passes++;
      if (j < 3) s++;
      cyc();
    end
    #1;
    checks++; if (ifa.count !== 2'd3) $display("FAIL bp_full_count got %0d exp 3", ifa.count); else passes++;
    checks++; if (ifa.q !== 8'h21) $display("FAIL bp_full_q got %h exp 21", ifa.q); else passes++;
    ifa.out_ready = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bp_pass_in_ready got %b exp 1", ifa.in_ready); else passes++;
    cyc();
    ifa.out_ready = 1'b0;
    #1;
    checks++; if (ifa.count !== 2'd3) $display("FAIL bp_after_count got %0d exp 3", ifa.count); else passes++;
    checks++; if (ifa.q !== 8'h22) $display("FAIL bp_after_q got %h exp 22", ifa.q); else passes++;
    checks++; if (ifa.in_ready !== 1'b0) $display("FAIL bp_after_in_ready got %b exp 0", ifa.in_ready); else passes++;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ifa.out_valid !== 1'b1 || ifa.q !== 8'(8'h22 + k)) $display("FAIL bp_drain k=%0d got %h/%b exp %h/1", k, ifa.q, ifa.out_valid, 8'(8'h22 + k)); else passes++;
      cyc();
    end
    checks++; if (ifa.out_valid !== 1'b0 || ifa.count !== 2'd0) $display("FAIL bp_empty got %b/%0d exp 0/0", ifa.out_valid, ifa.count); else passes++;
  endtask

  task automatic test_bubble();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.d = 8'h31; cyc();
    ifa.in_valid = 1'b0;
    repeat (4) cyc();
    checks++; if (ifa.count !== 2'd1 || ifa.q !== 8'h31) $display("FAIL bub_single got %0d/%h exp 1/31", ifa.count, ifa.q); else passes++;
    ifa.in_valid = 1'b1; ifa.d = 8'h32;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bub_in_ready_a got %b exp 1", ifa.in_ready); else passes++;
    cyc();
    ifa.d = 8'h33;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bub_in_ready_b got %b exp 1", ifa.in_ready); else passes++;
    cyc();
    ifa.in_valid = 1'b0;
    #1;
    checks++; if (ifa.count !== 2'd3) $display("FAIL bub_count got %0d exp 3", ifa.count); else passes++;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ifa.out_valid !== 1'b1 || ifa.q !== 8'(8'h31 + k)) $display("FAIL bub_order k=%0d got %h/%b exp %h/1", k, ifa.q, ifa.out_valid, 8'(8'h31 + k)); else passes++;
      cyc();
    end
    checks++; if (ifa.count !== 2'd0) $display("FAIL bub_empty_count got %0d exp 0", ifa.count); else passes++;
  endtask

  task automatic test_clear();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.d = 8'h41; cyc();
    ifa.d = 8'h42; cyc();
    ifa.in_valid = 1'b0; cyc();
    checks++; if (ifa.count !== 2'd2 || ifa.q !== 8'h41) $display("FAIL clr_pre got %0d/%h exp 2/41", ifa.count, ifa.q); else passes++;
    ifa.clear = 1'b1; ifa.in_valid = 1'b1; ifa.d = 8'h43; ifa.out_ready = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b0) $display("FAIL clr_in_ready got %b exp 0", ifa.in_ready); else passes++;
    cyc();
    ifa.clear = 1'b0; ifa.in_valid = 1'b0;
    #1;
    checks++; if (ifa.count !== 2'd0) $display("FAIL clr_count got %0d exp 0", ifa.count); else passes++;
    checks++; if (ifa.out_valid !== 1'b0) $display("FAIL clr_out_valid got %b exp 0", ifa.out_valid); else passes++;
    checks++; if (ifa.q !== 8'hA5) $display("FAIL clr_q got %h exp a5", ifa.q); else passes++;
    checks++; if (ifa.in_ready !== 1'b1) $display("FAIL clr_after_in_ready got %b exp 1", ifa.in_ready); else passes++;
    cyc();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.count !== 2'd0) $display("FAIL clr_no_ghost got %b/%0d exp 0/0", ifa.out_valid, ifa.count); else passes++;
  endtask

  task automatic test_depth1();
    bit          ev;
    bit          er;
    bit          r;
    logic [31:0] eq;
    int          n;
    rst_b_n = 1'b1;
    #1 rst_b_n = 1'b0;
    #1;
    checks++; if (ifb.q !== 32'hDEADBEEF) $display("FAIL d1_rst_q got %h exp deadbeef", ifb.q); else passes++;
    checks++; if (ifb.out_valid !== 1'b0 || ifb.count !== 1'b0) $display("FAIL d1_rst_state got %b/%0d exp 0/0", ifb.out_valid, ifb.count); else passes++;
    checks++; if (ifb.in_ready !== 1'b0) $display("FAIL d1_rst_in_ready got %b exp 0", ifb.in_ready); else passes++;
    cyc();
    rst_b_n = 1'b1;
    #1;
    checks++; if (ifb.in_ready !== 1'b1) $display("FAIL d1_release_in_ready got %b exp 1", ifb.in_ready); else passes++;
    cyc();
    ev = 1'b0; eq = 32'h0; n = 0;
    for (int i = 0; i < 12; i++) begin
      r = (i < 8) ? (i % 2 == 1) : 1'b1;
      ifb.out_ready = r;
      ifb.in_valid = 1'b1;
      ifb.d = 32'hC0DE0000 + 32'(n);
      #1;
      er = !ev || r;
      checks++; if (ifb.in_ready !== er) $display("FAIL d1_in_ready i=%0d got %b exp %b", i, ifb.in_ready, er); else passes++;
      checks++; if (ifb.out_valid !== ev || ifb.count !== ev) $display("FAIL d1_valid i=%0d got %b/%0d exp %b", i, ifb.out_valid, ifb.count, ev); else passes++;
      if (ev) begin
        checks++; if (ifb.q !== eq) $display("FAIL d1_q i=%0d got %h exp %h", i, ifb.q, eq); else passes++;
      end
      cyc();
      if (er) begin
        ev = 1'b1;
        eq = 32'hC0DE0000 + 32'(n);
        n++;
      end
    end
    ifb.clear = 1'b1; ifb.in_valid = 1'b0;
    #1;
    checks++; if (ifb.in_ready !== 1'b0) $display("FAIL d1_clr_in_ready got %b exp 0", ifb.in_ready); else passes++;
    cyc();
    ifb.clear = 1'b0;
    #1;
    checks++; if (ifb.out_valid !== 1'b0 || ifb.count !== 1'b0) $display("FAIL d1_clr_state got %b/%0d exp 0/0", ifb.out_valid, ifb.count); else passes++;
    checks++; if (ifb.q !== eq) $display("FAIL d1_clr_q_hold got %h exp %h", ifb.q, eq); else passes++;
  endtask

  initial begin
    ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.d = 8'h00; ifa.out_ready = 1'b0;
    ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.d = 32'h0; ifb.out_ready = 1'b0;
    rst_b_n = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_clear();
    test_depth1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
